// File: rtl/uart_rx_ctrl.sv
// UART receive sequencer: start-edge-aligned bit timing, LSB-first shift-in, stop check.
// Optional even parity bit between data and stop: define UART_RX_PARITY_EN.
module uart_rx_ctrl #(
  parameter int BAUD_W = 15,
  parameter int DATA_W = 8
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              rx_i,
  input  logic [BAUD_W-1:0] baud_i,
  output logic [DATA_W-1:0] data_o,
  output logic              valid_o,
  output logic              frame_err_o,
  output logic              parity_err_o,
  output logic              busy_o
);

  localparam int IDX_W = $clog2(DATA_W + 1);

`ifdef UART_RX_PARITY_EN
  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
`else
  typedef enum logic [2:0] {IDLE, START, DATA, STOP} state_t;
`endif

  state_t              state;
  logic [BAUD_W-1:0]   cnt;
  logic [DATA_W-1:0]   sr;
  logic [IDX_W-1:0]    idx;
  logic                rx_m, rx_s, rx_d;
  logic                start_c;
  logic                tick;
  logic [DATA_W:0]     sr_cat;
  logic                par_mis;

  // Line idles high, so the synchroniser resets to 1 to avoid a fake start edge.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      rx_m <= 1'b1;
      rx_s <= 1'b1;
      rx_d <= 1'b1;
    end else begin
      rx_m <= rx_i;
      rx_s <= rx_m;
      rx_d <= rx_s;
    end
  end

  assign start_c = rx_d & ~rx_s;
  assign tick    = (state != IDLE) && (cnt == '0);
  assign sr_cat  = {rx_s, sr};
  assign busy_o  = (state != IDLE);

`ifndef UART_RX_PARITY_EN
  assign par_mis      = 1'b0;
  assign parity_err_o = 1'b0;
`endif

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state       <= IDLE;
      cnt         <= '0;
      sr          <= '0;
      idx         <= '0;
      data_o      <= '0;
      valid_o     <= 1'b0;
      frame_err_o <= 1'b0;
`ifdef UART_RX_PARITY_EN
      par_mis      <= 1'b0;
      parity_err_o <= 1'b0;
`endif
    end else begin
      valid_o     <= 1'b0;
      frame_err_o <= 1'b0;
`ifdef UART_RX_PARITY_EN
      parity_err_o <= 1'b0;
`endif
      if (state != IDLE)
        cnt <= tick ? baud_i : cnt - BAUD_W'(1);

      case (state)
        IDLE: begin
          // Half-period preload puts every later tick at mid-bit.
          if (start_c) begin
            cnt   <= baud_i >> 1;
            state <= START;
          end
        end
        START: begin
          if (tick) begin
            if (!rx_s) begin
              idx   <= '0;
              state <= DATA;
`ifdef UART_RX_PARITY_EN
              par_mis <= 1'b0;
`endif
            end else begin
              state <= IDLE;
            end
          end
        end
        DATA: begin
          if (tick) begin
            sr  <= sr_cat[DATA_W:1];
            idx <= idx + IDX_W'(1);
            if (idx == IDX_W'(DATA_W - 1)) begin
`ifdef UART_RX_PARITY_EN
              state <= PARITY;
`else
              state <= STOP;
`endif
            end
          end
        end
`ifdef UART_RX_PARITY_EN
        PARITY: begin
          if (tick) begin
            par_mis <= rx_s ^ (^sr);
            state   <= STOP;
          end
        end
`endif
        STOP: begin
          if (tick) begin
            if (rx_s && !par_mis) begin
              data_o  <= sr;
              valid_o <= 1'b1;
            end
            frame_err_o <= ~rx_s;
`ifdef UART_RX_PARITY_EN
            parity_err_o <= par_mis;
`endif
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_rx_ctrl.sv
// Scoreboard bench for uart_rx_ctrl at 10 clocks per bit, 8 data bits.
module tb_uart_rx_ctrl;
  localparam int BAUD_W   = 15;
  localparam int DATA_W   = 8;
  localparam int BIT_CLKS = 10;

  logic              clk_i = 1'b0;
  logic              rst_i = 1'b1;
  logic              rx_i  = 1'b1;
  logic [BAUD_W-1:0] baud_i = 15'd9;
  logic [DATA_W-1:0] data_o;
  logic              valid_o, frame_err_o, parity_err_o, busy_o;

  uart_rx_ctrl #(.BAUD_W(BAUD_W), .DATA_W(DATA_W)) dut (
    .clk_i(clk_i), .rst_i(rst_i), .rx_i(rx_i), .baud_i(baud_i),
    .data_o(data_o), .valid_o(valid_o), .frame_err_o(frame_err_o),
    .parity_err_o(parity_err_o), .busy_o(busy_o)
  );

  always #5 clk_i = ~clk_i;

  int n_chk  = 0;
  int n_fail = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // kind = {valid, frame_err, parity_err}
  typedef struct {
    logic [2:0] kind;
    logic [7:0] data;
  } exp_t;
  exp_t sb[$];
  exp_t mon_e;

  task automatic expect_ev(input logic [2:0] kind, input logic [7:0] d);
    exp_t e;
    e.kind = kind;
    e.data = d;
    sb.push_back(e);
  endtask

  int       cyc = 0;
  int       fall_cyc = 0;
  bit       lat_arm = 1'b0;
  int       busy_cnt = 0;
  logic [2:0] pulse_prev = 3'b000;
  logic [2:0] pulse_cur;

  always @(posedge clk_i) cyc <= cyc + 1;

  always @(negedge clk_i) begin
    pulse_cur = {valid_o, frame_err_o, parity_err_o};
    if (busy_o) busy_cnt++;
    if (!rst_i && pulse_cur != 3'b000) begin
      if (sb.size() == 0) begin
        chk("unexpected_pulse", {29'd0, pulse_cur}, 32'd0);
      end else begin
        mon_e = sb.pop_front();
        chk("event_kind", {29'd0, pulse_cur}, {29'd0, mon_e.kind});
        if (mon_e.kind[2]) chk("rx_data", {24'd0, data_o}, {24'd0, mon_e.data});
      end
      if (lat_arm && valid_o) begin
        chk("latency_97_to_99", {31'd0, (cyc - fall_cyc) >= 97 && (cyc - fall_cyc) <= 99}, 32'd1);
        lat_arm = 1'b0;
      end
      if ((pulse_prev & pulse_cur) != 3'b000)
        chk("pulse_one_cycle", {29'd0, pulse_prev & pulse_cur}, 32'd0);
    end
    pulse_prev = pulse_cur;
  end

  task automatic drive_bit(input logic b);
    rx_i = b;
    repeat (BIT_CLKS) @(negedge clk_i);
  endtask

  task automatic idle(input int n);
    rx_i = 1'b1;
    repeat (n) @(negedge clk_i);
  endtask

  task automatic send_frame(input logic [7:0] d, input logic stop_b, input logic par_b);
    fall_cyc = cyc;
    drive_bit(1'b0);
    for (int i = 0; i < DATA_W; i++) drive_bit(d[i]);
`ifdef UART_RX_PARITY_EN
    drive_bit(par_b);
`else
    if (par_b) rx_i = 1'b1;
`endif
    drive_bit(stop_b);
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_data"},  {24'd0, data_o}, 32'd0);
    chk({tag, "_valid"}, {31'd0, valid_o}, 32'd0);
    chk({tag, "_ferr"},  {31'd0, frame_err_o}, 32'd0);
    chk({tag, "_perr"},  {31'd0, parity_err_o}, 32'd0);
    chk({tag, "_busy"},  {31'd0, busy_o}, 32'd0);
  endtask

  logic [7:0] abort_b = 8'h55;

  initial begin
    repeat (3) @(negedge clk_i);
    chk_all_zero("reset");
    rst_i = 1'b0;
    idle(5);

    // Good frame, with latency window on the first valid.
    expect_ev(3'b100, 8'hA5);
    lat_arm = 1'b1;
    send_frame(8'hA5, 1'b1, ^8'hA5);
    idle(20);
    chk("a5_held", {24'd0, data_o}, 32'h0000_00A5);

    // Three-clock low glitch: false start, busy only until the start sample.
    busy_cnt = 0;
    rx_i = 1'b0;
    repeat (3) @(negedge clk_i);
    idle(20);
    chk("glitch_busy_cycles", busy_cnt, 32'd5);
    chk("glitch_back_idle", {31'd0, busy_o}, 32'd0);

    // Stop bit low: frame error only, data held.
    expect_ev(3'b010, 8'h00);
    send_frame(8'h3C, 1'b0, ^8'h3C);
    idle(20);
    chk("ferr_data_hold", {24'd0, data_o}, 32'h0000_00A5);

    // Back-to-back with no idle gap.
    expect_ev(3'b100, 8'h00);
    expect_ev(3'b100, 8'hFF);
    send_frame(8'h00, 1'b1, 1'b0);
    send_frame(8'hFF, 1'b1, 1'b0);
    idle(20);
    chk("b2b_last", {24'd0, data_o}, 32'h0000_00FF);

    // Abort mid-frame (bit 4 of 0x55) with reset.
    drive_bit(1'b0);
    for (int i = 0; i < 4; i++) drive_bit(abort_b[i]);
    rx_i = abort_b[4];
    repeat (5) @(negedge clk_i);
    rst_i = 1'b1;
    repeat (2) @(negedge clk_i);
    chk_all_zero("in_reset");
    rx_i = 1'b1;
    repeat (3) @(negedge clk_i);
    rst_i = 1'b0;
    idle(30);
    chk("post_abort_idle", {31'd0, busy_o}, 32'd0);
    expect_ev(3'b100, 8'h81);
    send_frame(8'h81, 1'b1, ^8'h81);
    idle(20);

`ifdef UART_RX_PARITY_EN
    // 0x07 has three ones, so the correct even-parity bit is 1.
    expect_ev(3'b001, 8'h00);
    send_frame(8'h07, 1'b1, 1'b0);
    idle(20);
    chk("perr_data_hold", {24'd0, data_o}, 32'h0000_0081);
    expect_ev(3'b100, 8'h07);
    send_frame(8'h07, 1'b1, 1'b1);
    idle(20);
`endif

    for (int i = 0; i < 200 && sb.size() != 0; i++) @(negedge clk_i);
    chk("scoreboard_drained", sb.size(), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
